// File: rtl/peripheral_bfm_master_arbiter.sv
// Round-robin arbiter that shares one single-beat AXI master port among NREQ requesters.
// Each grant becomes one AW+W+B or AR+R transaction; only one is ever in flight.
module peripheral_bfm_master_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*32-1:0]   req_addr,
  input  logic [NREQ*32-1:0]   req_wdata,
  input  logic [NREQ*4-1:0]    req_strb,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic [31:0]          awadr,
  output logic                 awvalid,
  input  logic                 awready,
  output logic [31:0]          wrdata,
  output logic [3:0]           wstrb,
  output logic                 wvalid,
  input  logic                 wready,
  input  logic [1:0]           bresp,
  input  logic                 bvalid,
  output logic                 bready,
  output logic [31:0]          araddr,
  output logic                 arvalid,
  input  logic                 arready,
  input  logic [31:0]          rdata,
  input  logic [1:0]           rresp,
  input  logic                 rvalid,
  output logic                 rready
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA} state_t;

  state_t                state, state_nxt;
  logic [IW-1:0]         rr_ptr, gnt, gnt_q, idx;
  logic                  found, grant;
  logic [NREQ-1:0][31:0] addr_v, wdata_v;
  logic [NREQ-1:0][3:0]  strb_v;
  logic [31:0]           addr_q, wdata_q;
  logic [3:0]            strb_q;

  assign addr_v  = req_addr;
  assign wdata_v = req_wdata;
  assign strb_v  = req_strb;

  // Scan starts just after the last winner, so the previous grantee has lowest priority.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(rr_ptr) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  assign grant = (state == IDLE) && found;

  // Gated by reset so the accept pulse is also quiet while the block is held in reset.
  always_comb begin
    req_ready = '0;
    if (grant && aresetn) req_ready[gnt] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = req_we[gnt] ? WADDR : RADDR;
      WADDR:   if (!(awvalid && !awready) && !(wvalid && !wready)) state_nxt = WRESP;
      WRESP:   if (bvalid) state_nxt = IDLE;
      RADDR:   if (arready) state_nxt = RDATA;
      RDATA:   if (rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  assign awadr  = addr_q;
  assign araddr = addr_q;
  assign wrdata = wdata_q;
  assign wstrb  = strb_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr_ptr    <= IW'(NREQ - 1);
      gnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: if (grant) begin
          rr_ptr  <= gnt;
          gnt_q   <= gnt;
          addr_q  <= addr_v[gnt];
          wdata_q <= wdata_v[gnt];
          strb_q  <= strb_v[gnt];
          if (req_we[gnt]) begin
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
          end else begin
            arvalid <= 1'b1;
          end
        end
        // AW and W retire independently; B is only opened once both are gone.
        WADDR: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if (state_nxt == WRESP) bready <= 1'b1;
        end
        WRESP: if (bvalid) begin
          bready           <= 1'b0;
          rsp_valid[gnt_q] <= 1'b1;
          rsp_err          <= bresp[1];
          rsp_rdata        <= '0;
        end
        RADDR: if (arready) begin
          arvalid <= 1'b0;
          rready  <= 1'b1;
        end
        RDATA: if (rvalid) begin
          rready           <= 1'b0;
          rsp_valid[gnt_q] <= 1'b1;
          rsp_err          <= rresp[1];
          rsp_rdata        <= rdata;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_peripheral_bfm_master_arbiter.sv
// Randomized bench for peripheral_bfm_master_arbiter against a transaction-level
// model: round-robin grant rule, one outstanding AXI transaction, one-hot responses.
module tb_peripheral_bfm_master_arbiter;
  localparam int NREQ = 4;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [NREQ-1:0]    req_valid = '0, req_we = '0;
  logic [NREQ*32-1:0] req_addr = '0, req_wdata = '0;
  logic [NREQ*4-1:0]  req_strb = '0;
  logic [NREQ-1:0]    req_ready, rsp_valid;
  logic [31:0]        rsp_rdata, awadr, wrdata, araddr;
  logic               rsp_err, awvalid, wvalid, bready, arvalid, rready;
  logic [3:0]         wstrb;
  logic               awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]         bresp = '0, rresp = '0;
  logic [31:0]        rdata = '0;

  always #5 aclk = ~aclk;

  peripheral_bfm_master_arbiter #(.NREQ(NREQ)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .awadr(awadr), .awvalid(awvalid), .awready(awready),
    .wrdata(wrdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  int n_pass = 0, n_chk = 0;

  // Requester side of the model
  bit          pend [NREQ];
  bit          p_we [NREQ];
  logic [31:0] p_addr [NREQ], p_wdata [NREQ];
  logic [3:0]  p_strb [NREQ];
  int          last;
  int          grants [$];

  // Current transaction and slave behaviour
  bit          busy, cur_we, aw_done, w_done, ar_done;
  int          cur;
  logic [31:0] cur_addr, cur_wdata, cur_rdata;
  logic [3:0]  cur_strb;
  logic [1:0]  cur_resp;
  int          aw_wait, w_wait, ar_wait, b_wait, r_wait;
  bit          rsp_due, rsp_e;
  int          rsp_who;
  logic [31:0] rsp_dat;

  // Knobs
  bit          noise, rand_dly, flick_en;
  int          gen_pct;
  int          fx_aw, fx_w, fx_ar, fx_b, fx_r;
  logic [1:0]  fx_resp;
  logic [31:0] fx_rdata;

  int cyc, gcyc, last_rsp_cyc, last_lat, cnt_aw, cnt_w;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic post(input int i, input bit we, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
    pend[i] = 1'b1; p_we[i] = we; p_addr[i] = a; p_wdata[i] = d; p_strb[i] = s;
  endtask

  task automatic model_reset();
    busy = 0; rsp_due = 0; last = NREQ - 1;
    aw_done = 0; w_done = 0; ar_done = 0;
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
  endtask

  function automatic bit any_pend();
    bit r = 0;
    for (int i = 0; i < NREQ; i++) r |= pend[i];
    return r;
  endfunction

  task automatic grant_to(input int g);
    busy = 1; cur = g; last = g; pend[g] = 0; grants.push_back(g); gcyc = cyc;
    cur_we = p_we[g]; cur_addr = p_addr[g]; cur_wdata = p_wdata[g]; cur_strb = p_strb[g];
    aw_done = 0; w_done = 0; ar_done = 0;
    if (rand_dly) begin
      aw_wait = $urandom_range(0, 3); w_wait = $urandom_range(0, 3); ar_wait = $urandom_range(0, 3);
      b_wait = $urandom_range(0, 4);  r_wait = $urandom_range(0, 4);
      cur_resp = 2'($urandom); cur_rdata = $urandom;
    end else begin
      aw_wait = fx_aw; w_wait = fx_w; ar_wait = fx_ar; b_wait = fx_b; r_wait = fx_r;
      cur_resp = fx_resp; cur_rdata = fx_rdata;
    end
  endtask

  task automatic complete(input logic [31:0] d, input bit e);
    busy = 0; rsp_due = 1; rsp_who = cur; rsp_dat = d; rsp_e = e;
  endtask

  task automatic drive();
    bit aw_act, w_act, ar_act, b_act, r_act;
    for (int i = 0; i < NREQ; i++)
      if (!pend[i] && gen_pct > 0 && int'($urandom_range(0, 99)) < gen_pct)
        post(i, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom));
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = pend[i]; req_we[i] = p_we[i];
      req_addr[32*i +: 32] = p_addr[i]; req_wdata[32*i +: 32] = p_wdata[i];
      req_strb[4*i +: 4] = p_strb[i];
      // Short-lived requests while busy must never be granted
      if (flick_en && busy && !pend[i] && $urandom_range(0, 7) == 0) begin
        req_valid[i] = 1'b1; req_we[i] = 1'($urandom_range(0, 1));
      end
    end
    aw_act = busy && cur_we && !aw_done;
    w_act  = busy && cur_we && !w_done;
    ar_act = busy && !cur_we && !ar_done;
    b_act  = busy && cur_we && aw_done && w_done;
    r_act  = busy && !cur_we && ar_done;
    awready = (aw_act && aw_wait == 0) || (noise && $urandom_range(0, 3) == 0);
    wready  = (w_act && w_wait == 0)   || (noise && $urandom_range(0, 3) == 0);
    arready = (ar_act && ar_wait == 0) || (noise && $urandom_range(0, 3) == 0);
    if (aw_act && aw_wait > 0) aw_wait--;
    if (w_act && w_wait > 0) w_wait--;
    if (ar_act && ar_wait > 0) ar_wait--;
    bvalid = b_act && b_wait == 0;
    if (b_act && b_wait > 0) b_wait--;
    rvalid = r_act && r_wait == 0;
    if (r_act && r_wait > 0) r_wait--;
    bresp = bvalid ? cur_resp : 2'($urandom);
    rresp = rvalid ? cur_resp : 2'($urandom);
    rdata = rvalid ? cur_rdata : $urandom;
  endtask

  task automatic sample();
    logic [NREQ-1:0] er;
    logic [4:0]      eb;
    int              g;
    er = '0;
    if (rsp_due) er[rsp_who] = 1'b1;
    chk("rsp_valid", 64'(rsp_valid), 64'(er));
    if (rsp_due) begin
      chk("rsp_rdata", 64'(rsp_rdata), 64'(rsp_dat));
      chk("rsp_err", 64'(rsp_err), 64'(rsp_e));
      last_lat = cyc - gcyc; last_rsp_cyc = cyc; rsp_due = 0;
    end
    eb = {busy && cur_we && !aw_done, busy && cur_we && !w_done, busy && cur_we && aw_done && w_done,
          busy && !cur_we && !ar_done, busy && !cur_we && ar_done};
    chk("aw_w_b_ar_r", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'(eb));
    if (awvalid) begin chk("awadr", 64'(awadr), 64'(cur_addr)); cnt_aw++; end
    if (wvalid)  begin chk("wdata", 64'({wstrb, wrdata}), 64'({cur_strb, cur_wdata})); cnt_w++; end
    if (arvalid) chk("araddr", 64'(araddr), 64'(cur_addr));
    g = -1;
    if (!busy)
      for (int k = 1; k <= NREQ; k++) begin
        int i = (last + k) % NREQ;
        if (g < 0 && pend[i]) g = i;
      end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(er));
    if (busy) begin
      if (eb[4] && awready) aw_done = 1;
      if (eb[3] && wready)  w_done = 1;
      if (eb[2] && bvalid)  complete('0, bresp[1]);
      if (eb[1] && arready) ar_done = 1;
      if (eb[0] && rvalid)  complete(rdata, rresp[1]);
    end
    if (g >= 0) grant_to(g);
  endtask

  task automatic cycle();
    @(negedge aclk);
    cyc++;
    drive();
    #1;
    sample();
  endtask

  task automatic run_idle(input int max);
    int n = 0;
    while ((busy || rsp_due || any_pend()) && n < max) begin cycle(); n++; end
    chk("drain", 64'(busy || rsp_due || any_pend()), 64'(0));
  endtask

  task automatic chk_rst();
    chk("rst_ctl", 64'({req_ready, rsp_valid, rsp_err, awvalid, wvalid, wstrb, bready, arvalid, rready}), 64'(0));
    chk("rst_addr", {awadr, araddr}, 64'(0));
    chk("rst_data", {wrdata, rsp_rdata}, 64'(0));
  endtask

  initial begin
    int n;
    noise = 0; rand_dly = 0; flick_en = 0; gen_pct = 0;
    fx_aw = 0; fx_w = 0; fx_ar = 0; fx_b = 0; fx_r = 0; fx_resp = 0; fx_rdata = 0;
    cyc = 0; gcyc = 0; last_rsp_cyc = 0; last_lat = 0; cnt_aw = 0; cnt_w = 0;
    model_reset();

    // Reset state, with requests asserted to confirm no accept leaks out
    req_valid = '1;
    repeat (3) @(negedge aclk);
    #1 chk_rst();
    @(negedge aclk);
    aresetn = 1'b1; req_valid = '0;

    // Single write, zero-wait slave
    post(0, 1, 32'h100, 32'hA5A5A5A5, 4'hF);
    run_idle(20);
    chk("wr_latency", 64'(last_lat), 64'(3));

    // Single read with SLVERR
    fx_resp = 2'b10; fx_rdata = 32'h12345678;
    post(2, 0, 32'h40, 32'h0, 4'h0);
    run_idle(20);
    chk("rd_latency", 64'(last_lat), 64'(3));
    fx_resp = 2'b00;

    // AW accepted late, W immediately
    fx_aw = 3; cnt_aw = 0; cnt_w = 0;
    post(1, 1, 32'h200, 32'h1, 4'h3);
    run_idle(30);
    chk("aw_hold_cycles", 64'(cnt_aw), 64'(4));
    chk("w_hold_cycles", 64'(cnt_w), 64'(1));
    fx_aw = 0;

    // Long B delay with another requester waiting
    fx_b = 10;
    post(0, 1, 32'h300, 32'h2, 4'hF);
    cycle();
    fx_b = 0;
    post(1, 0, 32'h304, 32'h0, 4'h0);
    grants.delete();
    n = 0;
    while (grants.size() == 0 && n < 40) begin cycle(); n++; end
    chk("bp_grant_who", 64'(grants.size() > 0 ? grants[0] : -1), 64'(1));
    chk("bp_grant_cycle", 64'(gcyc), 64'(last_rsp_cyc));
    run_idle(20);

    // Reset in the middle of a write address phase
    fx_aw = 5;
    post(3, 1, 32'h400, 32'h3, 4'hF);
    n = 0;
    while (!awvalid && n < 10) begin cycle(); n++; end
    chk("pre_rst_awvalid", 64'(awvalid), 64'(1));
    @(negedge aclk);
    aresetn = 1'b0; req_valid = '1;
    #1 chk_rst();
    model_reset();
    repeat (2) @(negedge aclk);
    aresetn = 1'b1; req_valid = '0; fx_aw = 0;

    // Fairness: everybody always requesting
    grants.delete();
    rand_dly = 1; noise = 1; gen_pct = 100;
    n = 0;
    while (grants.size() < 8 && n < 300) begin cycle(); n++; end
    for (int k = 0; k < 8; k++)
      chk("fair_order", 64'(grants.size() > k ? grants[k] : -1), 64'(k % NREQ));
    gen_pct = 0;
    run_idle(100);

    // Random traffic
    gen_pct = 25; flick_en = 1;
    repeat (3000) cycle();
    gen_pct = 0; flick_en = 0;
    run_idle(300);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
